// File: rtl/sys_axi_pkg.sv
// Shared AXI types for the write-response path: response codes, B record, encoder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package sys_axi_pkg;

  localparam int AXI_ID_W = `AXI_ID_WIDTH;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_e;

  // One B-channel record at the default ID width.
  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    axi_resp_e           resp;
  } axi_b_entry_t;

  // A decode error outranks a slave error; EXOKAY is never produced here.
  function automatic axi_resp_e encode_resp(input logic slverr, input logic decerr);
    if (decerr)      return AXI_DECERR;
    else if (slverr) return AXI_SLVERR;
    else             return AXI_OKAY;
  endfunction

endpackage

// File: rtl/sys_axi_b_if.sv
// AXI B channel bundle: bid/bresp/bvalid from the responder, bready back.
// Latency: wires only.
// Backpressure: bready from the slave modport side stalls the master side.
// Ports: master drives bid, bresp, bvalid and samples bready; slave is the mirror.
interface sys_axi_b #(
  parameter int ID_W = `AXI_ID_WIDTH
);
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (output bid, output bresp, output bvalid, input bready);
  modport slave  (input bid, input bresp, input bvalid, output bready);
endinterface

// File: rtl/sys_sync_fifo.sv
// Single-clock circular FIFO with a registered head word.
// Latency: a push is visible at head_dat/!empty the cycle after it is accepted.
// Backpressure: caller must not push when full; pop on empty is ignored.
// Ports: push/push_dat in, pop in, head_dat/full/empty/count out.
module sys_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic             do_pop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign rd_nxt = rd_ptr + PTR_W'(1);

  // Storage needs no reset; its contents are only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // head_dat is its own register so it keeps its last value after draining
  // and is untouched by pushes while an entry is already at the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_dat <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_nxt;
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (do_pop && count > CNT_W'(1)) begin
        head_dat <= mem[rd_nxt];
      end else if (push && (empty || (do_pop && count == CNT_W'(1)))) begin
        head_dat <= push_dat;
      end
    end
  end

endmodule

// File: rtl/sys_axi_b_gen.sv
// Write-response generator: encodes burst completions and replays them in order on AXI B.
// Latency: completion accepted at edge N appears on B in cycle N+1; no flow-through.
// Backpressure: cmpl_ready drops only when DEPTH records are held; bready stalls the head.
// Ports: clk/rst_n; cmpl_valid/ready/id/slverr/decerr in; b (B channel, master); pending out.
module sys_axi_b_gen
  import sys_axi_pkg::*;
#(
  parameter int ID_W  = `AXI_ID_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmpl_valid,
  output logic                       cmpl_ready,
  input  logic [ID_W-1:0]            cmpl_id,
  input  logic                       cmpl_slverr,
  input  logic                       cmpl_decerr,
  sys_axi_b.master                   b,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  typedef struct packed {
    logic [ID_W-1:0] id;
    axi_resp_e       resp;
  } b_entry_t;

  b_entry_t push_ent;
  b_entry_t head_ent;
  logic     push;
  logic     pop;
  logic     full;
  logic     empty;

  assign push_ent.id   = cmpl_id;
  assign push_ent.resp = encode_resp(cmpl_slverr, cmpl_decerr);

  // cmpl_ready looks only at occupancy, so a full buffer refuses a push even
  // in a cycle where the head is leaving.
  assign cmpl_ready = !full;
  assign push       = cmpl_valid && cmpl_ready;
  assign pop        = b.bvalid && b.bready;

  assign b.bvalid = !empty;
  assign b.bid    = head_ent.id;
  assign b.bresp  = head_ent.resp;

  sys_sync_fifo #(
    .WIDTH ($bits(b_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .full     (full),
    .empty    (empty),
    .count    (pending)
  );

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> !full);

  a_b_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (b.bvalid && !b.bready) |=> (b.bvalid && $stable(b.bid) && $stable(b.bresp)));

endmodule

// File: tb/tb_sys_axi_b_gen.sv
module tb_sys_axi_b_gen;
  import sys_axi_pkg::*;

  localparam int ID_W  = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmpl_valid;
  logic            cmpl_ready;
  logic [ID_W-1:0] cmpl_id;
  logic            cmpl_slverr;
  logic            cmpl_decerr;
  logic [2:0]      pending;

  sys_axi_b #(.ID_W(ID_W)) bif ();

  sys_axi_b_gen #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmpl_valid  (cmpl_valid),
    .cmpl_ready  (cmpl_ready),
    .cmpl_id     (cmpl_id),
    .cmpl_slverr (cmpl_slverr),
    .cmpl_decerr (cmpl_decerr),
    .b           (bif),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [5:0] mq[$];   // expected B records {id, resp}, oldest first
  logic       acc;

  function automatic logic [1:0] enc(input logic slv, input logic dec);
    return dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks outputs against the queue model, then advances one clock with the
  // inputs currently driven and updates the model.
  task automatic step();
    int sz;
    sz = mq.size();
    chk("ready", 32'(cmpl_ready), 32'(sz != DEPTH));
    chk("bvalid", 32'(bif.bvalid), 32'(sz != 0));
    chk("pending", 32'(pending), 32'(sz));
    if (sz != 0) chk("head", 32'({bif.bid, bif.bresp}), 32'(mq[0]));
    acc = cmpl_valid && (sz != DEPTH);
    if (sz != 0 && bif.bready) void'(mq.pop_front());
    if (acc) mq.push_back({cmpl_id, enc(cmpl_slverr, cmpl_decerr)});
    cyc();
  endtask

  initial begin
    int n;
    int nid;
    int sent;

    rst_n       = 1'b0;
    cmpl_valid  = 1'b0;
    cmpl_id     = '0;
    cmpl_slverr = 1'b0;
    cmpl_decerr = 1'b0;
    bif.bready  = 1'b0;
    #12;
    @(negedge clk);
    chk("rst_bvalid", 32'(bif.bvalid), 0);
    chk("rst_ready", 32'(cmpl_ready), 1);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_bid", 32'(bif.bid), 0);
    chk("rst_bresp", 32'(bif.bresp), 0);
    rst_n = 1'b1;
    cyc();

    // Single write
    cmpl_valid = 1'b1; cmpl_id = 4'd3; bif.bready = 1'b1;
    step();
    cmpl_valid = 1'b0;
    chk("single_bvalid", 32'(bif.bvalid), 1);
    chk("single_bid", 32'(bif.bid), 3);
    chk("single_bresp", 32'(bif.bresp), 0);
    step();
    chk("single_drop", 32'(bif.bvalid), 0);
    chk("single_pending", 32'(pending), 0);
    chk("single_bid_hold", 32'(bif.bid), 3);

    // Encoding
    bif.bready = 1'b0;
    cmpl_valid = 1'b1; cmpl_id = 4'd1; cmpl_slverr = 1'b1; cmpl_decerr = 1'b0;
    step();
    cmpl_id = 4'd2; cmpl_slverr = 1'b0; cmpl_decerr = 1'b1;
    step();
    cmpl_id = 4'd5; cmpl_slverr = 1'b1; cmpl_decerr = 1'b1;
    step();
    cmpl_valid = 1'b0; cmpl_slverr = 1'b0; cmpl_decerr = 1'b0;
    chk("enc_pending", 32'(pending), 3);
    chk("enc_bid0", 32'(bif.bid), 1);
    chk("enc_bresp0", 32'(bif.bresp), 2);
    bif.bready = 1'b1;
    step();
    chk("enc_bid1", 32'(bif.bid), 2);
    chk("enc_bresp1", 32'(bif.bresp), 3);
    step();
    chk("enc_bid2", 32'(bif.bid), 5);
    chk("enc_bresp2", 32'(bif.bresp), 3);
    step();
    chk("enc_empty", 32'(bif.bvalid), 0);

    // Back-pressure until full, then drain
    bif.bready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmpl_valid = 1'b1; cmpl_id = 4'(i);
      chk("full_ready", 32'(cmpl_ready), 32'(i < 4));
      step();
    end
    chk("full_pending", 32'(pending), 4);
    chk("full_ready_low", 32'(cmpl_ready), 0);
    chk("full_bid", 32'(bif.bid), 0);
    nid = 4; n = 0; bif.bready = 1'b1;
    while ((nid < 6 || mq.size() != 0) && n < 20) begin
      cmpl_valid = (nid < 6); cmpl_id = 4'(nid);
      step();
      if (acc) nid++;
      n++;
    end
    cmpl_valid = 1'b0;
    chk("full_drain_cycles", 32'(n), 6);

    // Simultaneous push/pop at pending=2 across pointer wrap
    bif.bready = 1'b0;
    cmpl_valid = 1'b1; cmpl_id = 4'd10;
    step();
    cmpl_id = 4'd11;
    step();
    chk("simul_fill", 32'(pending), 2);
    bif.bready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cmpl_id = 4'((12 + k) % 16);
      step();
      chk("simul_pending", 32'(pending), 2);
    end
    cmpl_valid = 1'b0;
    n = 0;
    while (mq.size() != 0 && n < 10) begin
      step();
      n++;
    end
    chk("simul_drained", 32'(bif.bvalid), 0);

    // Random traffic with toggling bready
    sent = 0; n = 0;
    while ((sent < 200 || mq.size() != 0) && n < 5000) begin
      cmpl_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      cmpl_id     = 4'($urandom_range(0, 15));
      cmpl_slverr = 1'($urandom_range(0, 1));
      cmpl_decerr = 1'($urandom_range(0, 1));
      bif.bready  = 1'($urandom_range(0, 1));
      step();
      if (acc) sent++;
      n++;
    end
    cmpl_valid = 1'b0; cmpl_slverr = 1'b0; cmpl_decerr = 1'b0;
    chk("rand_complete", 32'(sent == 200 && mq.size() == 0), 1);

    // Asynchronous reset with records held
    bif.bready = 1'b0;
    cmpl_valid = 1'b1;
    cmpl_id = 4'd7; step();
    cmpl_id = 4'd8; step();
    cmpl_id = 4'd9; step();
    cmpl_valid = 1'b0;
    chk("pre_rst_pending", 32'(pending), 3);
    chk("pre_rst_bvalid", 32'(bif.bvalid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bvalid", 32'(bif.bvalid), 0);
    chk("arst_pending", 32'(pending), 0);
    chk("arst_ready", 32'(cmpl_ready), 1);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cmpl_valid = 1'b1; cmpl_id = 4'd6; bif.bready = 1'b1;
    step();
    cmpl_valid = 1'b0;
    chk("post_rst_bvalid", 32'(bif.bvalid), 1);
    chk("post_rst_bid", 32'(bif.bid), 6);
    step();
    chk("post_rst_empty", 32'(bif.bvalid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
